// File: rtl/iob_nco_core.sv
// iob_nco_core: fractional-period NCO in the output clock domain.
// Produces clk_o whose average period is a fixed-point number of clk_i
// cycles, dithering each period between floor and ceil lengths.
module iob_nco_core #(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned FRAC_W   = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                soft_reset_i,
  input  logic                enable_i,
  input  logic                period_wen_i,
  input  logic [PERIOD_W-1:0] period_wdata_i,
  output logic                clk_o,
  output logic                pulse_o,
  output logic                active_o,
  output logic                period_err_o
);

  localparam int unsigned INT_W = PERIOD_W - FRAC_W;
  localparam int unsigned CW    = INT_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [PERIOD_W-1:0]   shadow_q, shadow_d;
  logic [PERIOD_W-1:0]   act_period_q, act_period_d;
  logic [FRAC_W-1:0]     acc_q, acc_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  clk_q, clk_d;
  logic                  pulse_q, pulse_d;
  logic                  err_q, err_d;

  logic [PERIOD_W-1:0]   p;
  logic [INT_W-1:0]      p_int;
  logic [FRAC_W-1:0]     p_frac;
  logic                  p_valid;
  logic                  wdata_valid;
  logic [FRAC_W-1:0]     acc_base;
  logic [FRAC_W:0]       acc_sum;
  logic [CW-1:0]         start_len;
  logic [CW-1:0]         cnt_inc;
  logic                  terminal;

  // Period source with same-cycle write bypass, and the period-start arithmetic
  always_comb begin
    p           = period_wen_i ? period_wdata_i : shadow_q;
    p_int       = p[PERIOD_W-1:FRAC_W];
    p_frac      = p[FRAC_W-1:0];
    p_valid     = (p_int >= INT_W'(2));
    wdata_valid = (period_wdata_i[PERIOD_W-1:FRAC_W] >= INT_W'(2));
    // A start from IDLE always begins with a cleared accumulator
    acc_base    = (state_q == IDLE) ? '0 : acc_q;
    acc_sum     = {1'b0, acc_base} + {1'b0, p_frac};
    start_len   = {1'b0, p_int} + {{INT_W{1'b0}}, acc_sum[FRAC_W]};
    cnt_inc     = cnt_q + {{INT_W{1'b0}}, 1'b1};
    terminal    = (cnt_q == (len_q - {{INT_W{1'b0}}, 1'b1}));
  end

  // Next-state logic for the IDLE/RUN sequencer and the output waveform
  always_comb begin
    state_d      = state_q;
    shadow_d     = period_wen_i ? period_wdata_i : shadow_q;
    act_period_d = act_period_q;
    acc_d        = acc_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    clk_d        = clk_q;
    pulse_d      = 1'b0;
    err_d        = err_q;

    if (period_wen_i && wdata_valid) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        clk_d = 1'b0;
        if (enable_i) begin
          if (p_valid) begin
            state_d      = RUN;
            act_period_d = p;
            acc_d        = acc_sum[FRAC_W-1:0];
            len_d        = start_len;
            cnt_d        = '0;
            clk_d        = 1'b1;
            pulse_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!terminal) begin
          cnt_d = cnt_inc;
          clk_d = (cnt_inc < (len_q >> 1));
        end else if (!enable_i) begin
          state_d = IDLE;
          clk_d   = 1'b0;
          acc_d   = '0;
        end else if (!p_valid) begin
          state_d = IDLE;
          clk_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          act_period_d = p;
          acc_d        = acc_sum[FRAC_W-1:0];
          len_d        = start_len;
          cnt_d        = '0;
          clk_d        = 1'b1;
          pulse_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers: async reset, clock enable gates everything including soft reset
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      act_period_q <= '0;
      acc_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      clk_q        <= 1'b0;
      pulse_q      <= 1'b0;
      err_q        <= 1'b0;
    end else if (cke_i) begin
      if (soft_reset_i) begin
        state_q      <= IDLE;
        shadow_q     <= '0;
        act_period_q <= '0;
        acc_q        <= '0;
        len_q        <= '0;
        cnt_q        <= '0;
        clk_q        <= 1'b0;
        pulse_q      <= 1'b0;
        err_q        <= 1'b0;
      end else begin
        state_q      <= state_d;
        shadow_q     <= shadow_d;
        act_period_q <= act_period_d;
        acc_q        <= acc_d;
        len_q        <= len_d;
        cnt_q        <= cnt_d;
        clk_q        <= clk_d;
        pulse_q      <= pulse_d;
        err_q        <= err_d;
      end
    end
  end

  assign clk_o        = clk_q;
  assign pulse_o      = pulse_q;
  assign active_o     = (state_q == RUN);
  assign period_err_o = err_q;

endmodule

// File: tb/tb_iob_nco_core.sv
// Scoreboard bench for iob_nco_core: expected per-cycle output samples are
// queued from a period-level model as stimulus is applied, then popped and
// compared one per clock edge.
module tb_iob_nco_core;

  localparam int unsigned PW = 32;
  localparam int unsigned FW = 16;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          cke;
  logic          soft_reset;
  logic          enable;
  logic          wen;
  logic [PW-1:0] wdata;
  logic          clk_o;
  logic          pulse_o;
  logic          active_o;
  logic          period_err_o;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   pulse_seen = 0;
  logic [3:0]    sb_q[$];
  logic [FW-1:0] tb_acc = '0;

  always #5 clk = ~clk;

  iob_nco_core #(.PERIOD_W(PW), .FRAC_W(FW)) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .cke_i          (cke),
    .soft_reset_i   (soft_reset),
    .enable_i       (enable),
    .period_wen_i   (wen),
    .period_wdata_i (wdata),
    .clk_o          (clk_o),
    .pulse_o        (pulse_o),
    .active_o       (active_o),
    .period_err_o   (period_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic push_sample(input logic c, input logic pl, input logic a, input logic e);
    sb_q.push_back({c, pl, a, e});
  endtask

  // One output period of length len: high floor(len/2), pulse on first cycle
  task automatic push_period(input int unsigned len);
    for (int unsigned i = 0; i < len; i++) begin
      push_sample(i < len / 2, i == 0, 1'b1, 1'b0);
    end
  endtask

  // n periods at period word p, dithered through the fractional accumulator
  task automatic push_model(input logic [PW-1:0] p, input int unsigned n);
    logic [FW:0]  s;
    int unsigned  len;
    for (int unsigned k = 0; k < n; k++) begin
      s      = {1'b0, tb_acc} + {1'b0, p[FW-1:0]};
      tb_acc = s[FW-1:0];
      len    = int'(p[PW-1:FW]) + int'(s[FW]);
      push_period(len);
    end
  endtask

  task automatic push_idle(input int unsigned n, input logic e);
    for (int unsigned i = 0; i < n; i++) push_sample(1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic step(input int unsigned n);
    logic [3:0] exp;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (pulse_o) pulse_seen++;
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
        exp = sb_q.pop_front();
        check("clk_o",        32'(clk_o),        32'(exp[3]));
        check("pulse_o",      32'(pulse_o),      32'(exp[2]));
        check("active_o",     32'(active_o),     32'(exp[1]));
        check("period_err_o", 32'(period_err_o), 32'(exp[0]));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_clk"},    32'(clk_o),        32'd0);
    check({tag, "_pulse"},  32'(pulse_o),      32'd0);
    check({tag, "_active"}, 32'(active_o),     32'd0);
    check({tag, "_err"},    32'(period_err_o), 32'd0);
  endtask

  initial begin
    arst_n = 1'b0; cke = 1'b1; soft_reset = 1'b0; enable = 1'b0;
    wen = 1'b0; wdata = '0;
    #12;
    check_zero("reset");
    arst_n = 1'b1;
    @(posedge clk); #1;

    // 4.0: write and enable in the same cycle (bypass), 3 periods
    wen = 1'b1; wdata = 32'h0004_0000; enable = 1'b1; tb_acc = '0;
    push_model(32'h0004_0000, 3);
    step(1);
    wen = 1'b0;
    step(11);

    // Write 6.0 at cnt=1: current period stays 4, next two are 6
    push_model(32'h0004_0000, 1);
    step(2);
    wen = 1'b1; wdata = 32'h0006_0000;
    step(1);
    wen = 1'b0;
    step(1);
    push_model(32'h0006_0000, 2);
    step(12);

    // Write 4.0 on the start edge: applies to that very period
    wen = 1'b1; wdata = 32'h0004_0000;
    push_model(32'h0004_0000, 2);
    step(1);
    wen = 1'b0;
    step(7);

    // Drop enable at cnt=0: period completes, then idle
    push_model(32'h0004_0000, 1);
    step(1);
    enable = 1'b0;
    step(3);
    push_idle(3, 1'b0);
    tb_acc = '0;
    step(3);

    // 2.5: dithered lengths, 20 pulses in exactly 50 cycles
    wen = 1'b1; wdata = 32'h0002_8000; enable = 1'b1; tb_acc = '0;
    pulse_seen = 0;
    push_model(32'h0002_8000, 20);
    step(1);
    wen = 1'b0;
    step(49);
    check("pulses_in_50", 32'(pulse_seen), 32'd20);

    // 21st period leaves acc at one half; stop there
    push_model(32'h0002_8000, 1);
    step(1);
    enable = 1'b0;
    step(1);
    push_idle(2, 1'b0);
    tb_acc = '0;
    step(2);

    // Restart: accumulator must be cleared, so lengths 2 then 3
    enable = 1'b1;
    push_model(32'h0002_8000, 2);
    step(5);
    enable = 1'b0;
    push_idle(2, 1'b0);
    tb_acc = '0;
    step(2);

    // Invalid 1.5 with enable: stays idle, error set
    wen = 1'b1; wdata = 32'h0001_8000; enable = 1'b1;
    push_idle(1, 1'b1);
    step(1);
    wen = 1'b0;
    push_idle(3, 1'b1);
    step(3);

    // Valid 3.0 clears the error and starts
    wen = 1'b1; wdata = 32'h0003_0000; tb_acc = '0;
    push_model(32'h0003_0000, 3);
    step(1);
    wen = 1'b0;
    step(8);

    // Invalid 1.0 written mid-run: finish period, then idle with error
    push_model(32'h0003_0000, 1);
    step(1);
    wen = 1'b1; wdata = 32'h0001_0000;
    step(1);
    wen = 1'b0;
    step(1);
    push_idle(2, 1'b1);
    step(2);

    // Minimum valid period 2.0
    wen = 1'b1; wdata = 32'h0002_0000; tb_acc = '0;
    push_model(32'h0002_0000, 2);
    step(1);
    wen = 1'b0;
    step(3);

    // Soft reset mid-run
    soft_reset = 1'b1; enable = 1'b0;
    push_idle(1, 1'b0);
    step(1);
    soft_reset = 1'b0;
    push_idle(2, 1'b0);
    step(2);

    // Re-enable reproduces the reset-start sequence
    wen = 1'b1; wdata = 32'h0004_0000; enable = 1'b1; tb_acc = '0;
    push_model(32'h0004_0000, 1);
    step(1);
    wen = 1'b0;
    step(3);

    // cke low freezes state, masks soft reset and period capture
    push_sample(1'b1, 1'b1, 1'b1, 1'b0);
    step(1);
    cke = 1'b0; soft_reset = 1'b1; wen = 1'b1; wdata = 32'h0001_8000;
    for (int unsigned i = 0; i < 3; i++) push_sample(1'b1, 1'b1, 1'b1, 1'b0);
    step(3);
    cke = 1'b1; soft_reset = 1'b0; wen = 1'b0;
    push_sample(1'b1, 1'b0, 1'b1, 1'b0);
    push_sample(1'b0, 1'b0, 1'b1, 1'b0);
    push_sample(1'b0, 1'b0, 1'b1, 1'b0);
    push_model(32'h0004_0000, 1);
    step(7);

    // Async reset mid-period: outputs drop without a clock edge
    push_model(32'h0004_0000, 1);
    step(2);
    #2;
    arst_n = 1'b0;
    #1;
    check_zero("arst_async");
    sb_q.delete();
    @(posedge clk); #1;
    check_zero("arst_held");
    wen = 1'b1; wdata = 32'h0004_0000; tb_acc = '0;
    #2;
    arst_n = 1'b1;
    push_model(32'h0004_0000, 2);
    step(1);
    wen = 1'b0;
    step(7);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_nco_core.md
# iob_nco_core

Numerically controlled oscillator core in the NCO output clock domain. It sits directly downstream of the CSR-to-output-clock synchronizer and consumes its synchronized `enable`, `soft_reset` and `period` write strobe/data. It produces an output clock whose average period equals a fixed-point number of input clock cycles. Fractional periods are realized by dithering each output period between floor and ceil lengths with a fractional accumulator.

## Interface
Parameters:
- `PERIOD_W`, 32: period word width, unsigned fixed point.
- `FRAC_W`, 16: fractional bits of the period word. `INT_W = PERIOD_W-FRAC_W`.

Ports:
- `clk_i` in 1: NCO clock.
- `arst_n_i` in 1: reset, asynchronous, active-low.
- `cke_i` in 1: clock enable. When low, all state holds.
- `soft_reset_i` in 1: synchronous reset, already synchronized to `clk_i`.
- `enable_i` in 1: run request, synchronized level.
- `period_wen_i` in 1: one-cycle write strobe for `period_wdata_i`.
- `period_wdata_i` in PERIOD_W: period in input cycles; integer part `[PERIOD_W-1:FRAC_W]`, fraction `[FRAC_W-1:0]`.
- `clk_o` out 1: generated clock, registered.
- `pulse_o` out 1: one-cycle strobe on each output period start, registered.
- `active_o` out 1: high while in RUN.
- `period_err_o` out 1: sticky flag, set when a period with integer part < 2 is selected.

## Operation
- Registers:
  - `shadow` (PERIOD_W) is written on every `period_wen_i`.
  - `active` (PERIOD_W) holds the period in use.
  - `acc` (FRAC_W) is the fractional accumulator.
  - `len` (INT_W+1) is the current period length.
  - `cnt` (INT_W+1) counts 0..len-1.
  - FSM has two states: IDLE and RUN.
- Effective period source is `p`. It is `period_wdata_i` when `period_wen_i` is high in the same cycle, else `shadow`. This bypass is mandatory.
- Period start event. All of the following happen on one edge:
  - `active` ← `p`.
  - `{c, acc}` ← `acc + p[FRAC_W-1:0]`.
  - `len` ← `p[PERIOD_W-1:FRAC_W] + c`.
  - `cnt` ← 0.
  - `clk_o` ← 1 and `pulse_o` ← 1.
- In RUN, per edge: if `cnt` ≠ `len-1`, then `cnt` ← `cnt+1` and `clk_o` ← (`cnt+1` < `len>>1`). High time is floor(len/2) cycles; low time is ceil(len/2) cycles.
- IDLE → RUN when `enable_i`=1 and `p` is valid (integer part ≥ 2). The transition performs a period start with `acc` first cleared to 0.
- At `cnt`=`len-1` in RUN:
  - If `enable_i`=0: go to IDLE; `clk_o` stays 0; `acc` ← 0.
  - Else if `p` is invalid: go to IDLE and set `period_err_o`.
  - Else: perform a period start.
- Deasserting `enable_i` never truncates a period. The current period always completes.
- `period_err_o`:
  - Also set while in IDLE with `enable_i`=1 and `p` invalid.
  - Cleared by a `period_wen_i` carrying a valid value, by `soft_reset_i`, or by reset.
- Maximum `len` is 2^INT_W (all-ones integer part plus carry). `cnt` and `len` never overflow.
- `soft_reset_i`=1 with `cke_i`=1 resets all registers to reset values on that edge. It has priority over all other inputs.

## Timing
- Reset values: `clk_o`=0, `pulse_o`=0, `active_o`=0, `period_err_o`=0; `shadow`, `active`, `acc`, `len`, `cnt` = 0; state IDLE.
- Start latency: with `enable_i` and a valid `p` sampled at edge t, `clk_o`=`pulse_o`=`active_o`=1 after edge t.
- Period writes during RUN take effect at the next period start. A write landing exactly on the start edge applies to that period.
- Stop: `active_o` and `clk_o` are 0 after the terminal edge (`cnt`=`len-1`) of the last period.
- `arst_n_i` low at any time: outputs 0 immediately, independent of `clk_i`. Deassertion with `enable_i`=1 restarts as from IDLE.
- `cke_i`=0: no state change, including `soft_reset_i` and the `period_wen_i` capture.

## Test plan
- Period 0x00040000 (4.0), enable → `clk_o` high 2 / low 2 repeating; `pulse_o` every 4 cycles; first high 1 cycle after enable is sampled.
- Period 0x00028000 (2.5) → lengths 2,3,2,3…; high 1 cycle each; 20 pulses span exactly 50 cycles.
- Running at 4.0, write 0x00060000 at `cnt`=1 → current period stays 4 cycles; next periods are 6 (3 high / 3 low); a write on the start edge applies immediately.
- Running at 4.0, drop `enable_i` at `cnt`=0 → period completes 4 cycles, then `clk_o`=0 and `active_o`=0; `acc` is 0 on the next start.
- Write 0x00018000 (1.5), enable → stays IDLE with `period_err_o`=1; write 0x00030000 → error clears and output runs at 3 cycles (1 high / 2 low).
- Mid-run `soft_reset_i` pulse, and separately `arst_n_i` low mid-run → all outputs 0 (next edge / immediately); re-enable reproduces the reset-start sequence.
